// File: rtl/snn_pkg.sv
// Shared constants and types for the spiking-network event path.
//   EVENT_ADDR_W           : event address width seen by the neuron core
//   WEIGHTS_PER_EVENT      : weight loads the controller performs per event
//   SERVICE_CYCLES_DEFAULT : issue + weight loads + accumulate
//   sched_state_t          : scheduler FSM states
package snn_pkg;
  localparam int EVENT_ADDR_W           = 4;
  localparam int WEIGHTS_PER_EVENT      = 16;
  localparam int SERVICE_CYCLES_DEFAULT = WEIGHTS_PER_EVENT + 2;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } sched_state_t;
endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO holding granted event addresses.
// Ports:
//   clock, reset : posedge clock, synchronous active-high reset
//   push         : write push_data (caller guarantees not full)
//   pop          : advance head (caller guarantees not empty)
//   head         : oldest entry, valid when !empty
//   count        : occupancy 0..DEPTH
//   full, empty  : occupancy flags
module event_fifo
  import snn_pkg::*;
#(
  parameter  int WIDTH = EVENT_ADDR_W,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  // Storage needs no reset: entries are only read once count says they exist.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/event_scheduler.sv
// Round-robin collection of spike events from NUM_SRC sources, buffered in a
// FIFO and issued one at a time to the neuron-core load/accumulate controller.
// The controller has no ready, so each event owns a fixed SERVICE_CYCLES
// window during which event_addr is held stable.
// Ports:
//   clock, reset   : posedge clock, synchronous active-high reset
//   src_valid      : per-source request
//   src_addr       : packed addresses, source i at [i*ADDR_W +: ADDR_W]
//   src_ready      : one-hot grant (combinational from src_valid)
//   event_addr     : address of event in service (registered)
//   event_received : one-cycle issue pulse (registered)
//   busy           : an event is in service
//   fifo_count     : FIFO occupancy
module event_scheduler
  import snn_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int ADDR_W         = EVENT_ADDR_W,
  parameter int FIFO_DEPTH     = 8,
  parameter int SERVICE_CYCLES = SERVICE_CYCLES_DEFAULT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]     src_addr,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [ADDR_W-1:0]             event_addr,
  output logic                          event_received,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int SVC_W = $clog2(SERVICE_CYCLES);
  localparam logic [SVC_W-1:0] SVC_LAST = SVC_W'(SERVICE_CYCLES - 1);

  logic [SRC_W-1:0]  last_grant;
  logic [SRC_W-1:0]  grant_idx;
  logic [NUM_SRC-1:0] grant;
  logic              push, pop;
  logic [ADDR_W-1:0] push_data, fifo_head;
  logic              fifo_full, fifo_empty;

  sched_state_t      state_q, state_d;
  logic [SVC_W-1:0]  svc_cnt_q, svc_cnt_d;

  // Round-robin: first valid source at or after last_grant+1. Fullness is
  // judged on the current count only, so a same-cycle pop never frees a slot.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = last_grant;
    if (!fifo_full) begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        idx = int'(last_grant) + k;
        if (idx >= NUM_SRC) idx = idx - NUM_SRC;
        if (grant == '0 && src_valid[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = SRC_W'(idx);
        end
      end
    end
  end

  assign src_ready = grant;
  assign push      = |grant;
  assign push_data = src_addr[int'(grant_idx)*ADDR_W +: ADDR_W];

  always_ff @(posedge clock) begin
    if (reset)     last_grant <= SRC_W'(NUM_SRC - 1);
    else if (push) last_grant <= grant_idx;
  end

  event_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Service FSM: a pop starts a fresh window; the window's last cycle either
  // chains straight into the next event or drops back to IDLE.
  always_comb begin
    state_d   = state_q;
    svc_cnt_d = svc_cnt_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_d   = SERVICE;
          svc_cnt_d = '0;
        end
      end
      SERVICE: begin
        if (svc_cnt_q != SVC_LAST) begin
          svc_cnt_d = svc_cnt_q + 1'b1;
        end else if (!fifo_empty) begin
          pop       = 1'b1;
          svc_cnt_d = '0;
        end else begin
          state_d   = IDLE;
          svc_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        svc_cnt_d = '0;
      end
    endcase
  end

  // event_received is registered from the pop, so it is high exactly in the
  // first cycle of each window (state==SERVICE && svc_cnt==0).
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      svc_cnt_q      <= '0;
      event_addr     <= '0;
      event_received <= 1'b0;
    end else begin
      state_q        <= state_d;
      svc_cnt_q      <= svc_cnt_d;
      event_received <= pop;
      if (pop) event_addr <= fifo_head;
    end
  end

  assign busy = (state_q == SERVICE);

endmodule
